bid_cmd_seq: RTL

BID_CMD_SEQ -- requirements
Module: bid_cmd_seq

---
 rtl/bid_cmd_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bid_cmd_seq.sv
// bid_cmd_seq -- host command sequencer for the auction block.
//
// Host commands are queued in a DEPTH-entry FIFO and issued one at a time.
// An auction opcode (0..8) is presented on C_op/C_data for a single ISSUE
// cycle, and a_err is captured in the following cycle. A RUN opcode (4'hF)
// holds C_start high for N cycles (N = h_data[15:0], 0 treated as 1) and
// then waits for a_roundOver. Opcodes 9..14 are dropped and flagged on rej.
//
// Optional feature: define BIDSEQ_TIMEOUT_EN to abandon the round-over wait
// after 255 cycles and set the sticky timeout flag.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   h_valid/h_ready        host push handshake (h_ready = FIFO not full)
//   h_op, h_data           host opcode / operand
//   C_op, C_data, C_start  command outputs to the auction block
//   a_ready, a_err         auction block ready / error code
//   a_roundOver            auction round complete
//   busy                   sequencer active or FIFO non-empty
//   seq_err, err_cnt       last nonzero error captured / saturating count
//   rej                    one-cycle pulse when an illegal opcode is dropped
//   timeout                sticky round-over wait expiry flag
module bid_cmd_seq #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        h_valid,
   output logic        h_ready,
   input  logic [3:0]  h_op,
   input  logic [31:0] h_data,
   output logic [3:0]  C_op,
   output logic [31:0] C_data,
   output logic        C_start,
   input  logic        a_ready,
   input  logic [1:0]  a_err,
   input  logic        a_roundOver,
   output logic        busy,
   output logic [1:0]  seq_err,
   output logic [7:0]  err_cnt,
   output logic        rej,
   output logic        timeout
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, ROUND, WAIT_OVER} state_t;

   state_t state, state_nxt;

   // FIFO storage: {op, data}
   logic [35:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          empty, full;
   logic          illegal, push, push_store, pop;
   logic [35:0]   head;

   logic [3:0]    cur_op;
   logic [31:0]   cur_data;
   logic [15:0]   rnd_cnt;
   logic          issue_d;
   logic          timeout_hit;

   assign empty      = (count == '0);
   assign full       = (count == FULL_CNT);
   assign h_ready    = !full;
   assign illegal    = (h_op >= 4'd9) && (h_op <= 4'd14);
   assign push       = h_valid && h_ready;
   assign push_store = push && !illegal;
   assign pop        = (state == IDLE) && !empty && a_ready;
   assign head       = mem[rd_ptr];

   // ---------------- FIFO ----------------
   always_ff @(posedge clk) begin
      if (push_store) mem[wr_ptr] <= {h_op, h_data};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_store) wr_ptr <= wr_ptr + 1'b1;
         if (pop)        rd_ptr <= rd_ptr + 1'b1;
         case ({push_store, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

`ifdef BIDSEQ_TIMEOUT_EN
   logic [7:0] wait_cnt;

   // wait_cnt is 0 in the first WAIT_OVER cycle, so 254 marks the 255th.
   assign timeout_hit = (state == WAIT_OVER) && !a_roundOver && (wait_cnt == 8'd254);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         if (state == WAIT_OVER) wait_cnt <= wait_cnt + 1'b1;
         else                    wait_cnt <= '0;
         if (timeout_hit) timeout <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout     = 1'b0;
`endif

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pop) state_nxt = (head[35:32] == 4'hF) ? ROUND : ISSUE;
         end
         ISSUE: state_nxt = IDLE;
         ROUND: begin
            if (rnd_cnt <= 16'd1) state_nxt = WAIT_OVER;
         end
         WAIT_OVER: begin
            if (a_roundOver || timeout_hit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      C_op    = '0;
      C_data  = '0;
      C_start = 1'b0;
      busy    = !empty;
      case (state)
         ISSUE: begin
            C_op   = cur_op;
            C_data = cur_data;
            busy   = 1'b1;
         end
         ROUND: begin
            C_start = 1'b1;
            busy    = 1'b1;
         end
         WAIT_OVER: busy = 1'b1;
         default: ;
      endcase
   end

   // ---------------- datapath: popped entry, round counter, status ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cur_op   <= '0;
         cur_data <= '0;
         rnd_cnt  <= '0;
         issue_d  <= 1'b0;
         seq_err  <= '0;
         err_cnt  <= '0;
         rej      <= 1'b0;
      end else begin
         if (pop) begin
            cur_op   <= head[35:32];
            cur_data <= head[31:0];
            rnd_cnt  <= (head[15:0] == '0) ? 16'd1 : head[15:0];
         end else if (state == ROUND && rnd_cnt > 16'd1) begin
            rnd_cnt <= rnd_cnt - 1'b1;
         end
         issue_d <= (state == ISSUE);
         if (issue_d && a_err != '0) begin
            seq_err <= a_err;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
         end
         rej <= push && illegal;
      end
   end

endmodule
